adder_rr_sched: RTL and testbench

- Round-robin scheduler that shares one adder_32bit instance among NUM_REQ requesters.
- Each requester presents operands over a valid/ready handshake.
- The scheduler grants one requester, registers its operands, drives the shared adder, and returns a registered sum, carry-out and requester ID on a single response channel with backpressure.
- Sits between multiple arithmetic clients and the single adder datapath.

---
 rtl/adder_sched_pkg.sv | 32 +++
 rtl/adder_32bit.sv | 14 +
 rtl/adder_rr_sched_arb.sv | 35 +++
 rtl/adder_rr_sched.sv | 115 +++++++++++
 tb/tb_adder_rr_sched.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_sched_pkg.sv
// Shared types and helpers for the round-robin adder scheduler.
// Requester counts up to MAX_REQ are supported by rr_pick.
package adder_sched_pkg;

   localparam int ADD_W   = 32;
   localparam int MAX_REQ = 8;

   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } pick_t;

   // First valid requester at or after ptr, wrapping modulo n.
   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                     input logic [2:0]         ptr,
                                     input int                 n);
      pick_t p;
      int    i;
      p = '0;
      for (int k = 0; k < MAX_REQ; k++) begin
         i = (int'(ptr) + k) % n;
         if (k < n && !p.found && valid[i]) begin
            p.found = 1'b1;
            p.idx   = 3'(i);
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/adder_32bit.sv
// 32-bit unsigned adder built from two 16-bit slices with a rippled carry.
module adder_32bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] s,
   output logic        c32
);

   logic c16;

   assign {c16, s[15:0]}  = {1'b0, a[15:0]} + {1'b0, b[15:0]};
   assign {c32, s[31:16]} = {1'b0, a[31:16]} + {1'b0, b[31:16]} + {16'b0, c16};

endmodule

// File: rtl/adder_rr_sched_arb.sv
// rr_arbiter: combinational round-robin pick, valid vector + pointer to
// one-hot grant and encoded index.
module rr_arbiter
   import adder_sched_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    idx,
   output logic               found
);

   logic [MAX_REQ-1:0] v_ext;
   logic [2:0]         p_ext;
   pick_t              pick;

   always_comb begin
      v_ext              = '0;
      v_ext[NUM_REQ-1:0] = valid;
      p_ext              = '0;
      p_ext[ID_W-1:0]    = ptr;
      pick               = rr_pick(v_ext, p_ext, NUM_REQ);
   end

   assign found = pick.found;
   assign idx   = pick.idx[ID_W-1:0];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_gnt
      assign gnt[g] = pick.found && (pick.idx == 3'(g));
   end

endmodule

// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one adder_32bit among NUM_REQ requesters.
// Optional ADDER_SCHED_LOCK_EN adds req_lock to hold the pointer on a requester.
module adder_rr_sched
   import adder_sched_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*ADD_W-1:0] req_a,
   input  logic [NUM_REQ*ADD_W-1:0] req_b,
`ifdef ADDER_SCHED_LOCK_EN
   input  logic [NUM_REQ-1:0]       req_lock,
`endif
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [ADD_W-1:0]         rsp_sum,
   output logic                     rsp_c32
);

   state_t                          state, state_nx;
   logic [ID_W-1:0]                 rr_ptr, gnt_id, arb_idx, ptr_adv;
   logic [NUM_REQ-1:0]              arb_gnt;
   logic                            arb_found;
   logic [NUM_REQ-1:0][ADD_W-1:0]   a_arr, b_arr;
   logic [ADD_W-1:0]                op_a, op_b, add_s;
   logic                            add_c, req_hs, rsp_hs, lock_cur;

   assign a_arr = req_a;
   assign b_arr = req_b;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .valid (req_valid),
      .ptr   (rr_ptr),
      .gnt   (arb_gnt),
      .idx   (arb_idx),
      .found (arb_found)
   );

   adder_32bit u_add (
      .a   (op_a),
      .b   (op_b),
      .s   (add_s),
      .c32 (add_c)
   );

   // Gated by rst_n so no grant is offered while reset is held.
   assign req_ready = (state == IDLE && rst_n) ? arb_gnt : '0;
   assign req_hs    = arb_found && |(req_ready & req_valid);
   assign rsp_hs    = rsp_valid && rsp_ready;
   assign ptr_adv   = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;

`ifdef ADDER_SCHED_LOCK_EN
   logic gnt_lock;
   assign lock_cur = gnt_lock;
`else
   assign lock_cur = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req_hs) state_nx = CALC;
         CALC:    state_nx = RESP;
         RESP:    if (rsp_hs) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr    <= '0;
         gnt_id    <= '0;
         op_a      <= '0;
         op_b      <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
         rsp_c32   <= 1'b0;
`ifdef ADDER_SCHED_LOCK_EN
         gnt_lock  <= 1'b0;
`endif
      end else begin
         if (state == IDLE && req_hs) begin
            op_a     <= a_arr[arb_idx];
            op_b     <= b_arr[arb_idx];
            gnt_id   <= arb_idx;
`ifdef ADDER_SCHED_LOCK_EN
            gnt_lock <= req_lock[arb_idx];
`endif
         end
         if (state == CALC) begin
            rsp_sum   <= add_s;
            rsp_c32   <= add_c;
            rsp_id    <= gnt_id;
            rsp_valid <= 1'b1;
         end
         // A locked grant keeps the pointer so the same requester wins next.
         if (state == RESP && rsp_hs) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= lock_cur ? gnt_id : ptr_adv;
         end
      end
   end

endmodule

// File: tb/tb_adder_rr_sched.sv
// Bench for adder_rr_sched: transaction-level model checked every cycle plus
// directed literal expectations per scenario.
module tb_adder_rr_sched;

   localparam int N = 4;

   logic            clk, rst_n;
   logic [N-1:0]    req_valid, req_ready, req_lock;
   logic [N*32-1:0] req_a, req_b;
   logic            rsp_valid, rsp_ready, rsp_c32;
   logic [1:0]      rsp_id;
   logic [31:0]     rsp_sum;

   adder_rr_sched #(.NUM_REQ(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
`ifdef ADDER_SCHED_LOCK_EN
      .req_lock  (req_lock),
`endif
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_c32   (rsp_c32)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0, bad = 0, cyc = 0, hs_count = 0, rsp_count = 0;
   int lg_id[$];
   logic [31:0] lg_sum[$];
   logic lg_c[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++)
         if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   always @(posedge clk) cyc++;

   // Model: one outstanding op, response exactly two cycles after acceptance.
   int m_ptr = 0, m_id = 0, m_hs_cyc = 0;
   logic m_busy = 1'b0, m_lock = 1'b0, m_c;
   logic [31:0] m_sum;

   always @(negedge clk) begin
      int w;
      logic [N-1:0] exp_ready;
      logic exp_rv;
      logic [32:0] t;
      if (!rst_n) begin
         chk("rst_req_ready", 64'(req_ready), 64'd0);
         chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
         chk("rst_rsp_sum", 64'(rsp_sum), 64'd0);
         chk("rst_rsp_id", 64'(rsp_id), 64'd0);
         chk("rst_rsp_c32", 64'(rsp_c32), 64'd0);
         m_busy = 1'b0;
         m_ptr  = 0;
      end else begin
         exp_ready = '0;
         w = m_busy ? -1 : pick(req_valid, m_ptr);
         if (w >= 0) exp_ready[w] = 1'b1;
         chk("req_ready", 64'(req_ready), 64'(exp_ready));
         exp_rv = m_busy && (cyc >= m_hs_cyc + 2);
         chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
         if (exp_rv) begin
            chk("rsp_id", 64'(rsp_id), 64'(m_id));
            chk("rsp_sum", 64'(rsp_sum), 64'(m_sum));
            chk("rsp_c32", 64'(rsp_c32), 64'(m_c));
         end
         if (w >= 0) begin
            t = {1'b0, req_a[32*w +: 32]} + {1'b0, req_b[32*w +: 32]};
            m_sum = t[31:0];
            m_c   = t[32];
            m_id  = w;
            m_hs_cyc = cyc;
            m_busy = 1'b1;
`ifdef ADDER_SCHED_LOCK_EN
            m_lock = req_lock[w];
`else
            m_lock = 1'b0;
`endif
            hs_count++;
         end else if (exp_rv && rsp_ready) begin
            lg_id.push_back(int'(rsp_id));
            lg_sum.push_back(rsp_sum);
            lg_c.push_back(rsp_c32);
            m_busy = 1'b0;
            m_ptr  = m_lock ? m_id : (m_id + 1) % N;
            rsp_count++;
         end
      end
   end

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
   endtask

   task automatic wait_hs(input int n);
      int k = 0;
      while (hs_count < n && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      if (hs_count < n) chk("hs_timeout", 64'(hs_count), 64'(n));
   endtask

   task automatic wait_rsp(input int n);
      int k = 0;
      while (rsp_count < n && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      if (rsp_count < n) chk("rsp_timeout", 64'(rsp_count), 64'(n));
   endtask

   task automatic do_one(input int i, input logic [31:0] a, input logic [31:0] b);
      int h, r;
      h = hs_count + 1;
      r = rsp_count + 1;
      set_req(i, a, b);
      req_valid[i] = 1'b1;
      wait_hs(h);
      req_valid[i] = 1'b0;
      wait_rsp(r);
   endtask

   task automatic chk_last(input string nm, input int id, input logic [31:0] s, input logic c);
      int l;
      l = lg_id.size() - 1;
      if (l < 0) begin
         chk({nm, "_missing"}, 64'd0, 64'd1);
      end else begin
         chk({nm, "_id"}, 64'(lg_id[l]), 64'(id));
         chk({nm, "_sum"}, 64'(lg_sum[l]), 64'(s));
         chk({nm, "_c32"}, 64'(lg_c[l]), 64'(c));
      end
   endtask

   initial begin
      int base, h, r, k;
      int exp_lock[3];
      rst_n = 1'b0; req_valid = '1; req_a = '0; req_b = '0; req_lock = '0; rsp_ready = 1'b1;
      @(negedge clk);
      chk("lit_reset_ready", 64'(req_ready), 64'd0);
      chk("lit_reset_rvalid", 64'(rsp_valid), 64'd0);
      req_valid = '0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // Single op on requester 0
      do_one(0, 32'h5, 32'h3);
      chk_last("single", 0, 32'h8, 1'b0);

      // Carry boundaries
      do_one(2, 32'hFFFF_FFFF, 32'h1);
      chk_last("carry_full", 2, 32'h0, 1'b1);
      do_one(3, 32'h0000_FFFF, 32'h1);
      chk_last("carry_slice", 3, 32'h0001_0000, 1'b0);

      // All requesters valid: grant order 0,1,2,3,0
      for (int i = 0; i < N; i++) set_req(i, 32'(i * 16 + 1), 32'd100);
      base = lg_id.size();
      r = rsp_count + 5;
      req_valid = '1;
      wait_rsp(r);
      req_valid = '0;
      for (int i = 0; i < 5; i++) begin
         k = i % N;
         chk("rr_id", 64'(lg_id[base + i]), 64'(k));
         chk("rr_sum", 64'(lg_sum[base + i]), 64'(101 + 16 * k));
      end

      // Backpressure with requester 0 competing
      rsp_ready = 1'b0;
      set_req(1, 32'h1234_5678, 32'h1111_1111);
      set_req(0, 32'h7, 32'h9);
      h = hs_count + 1;
      req_valid[1] = 1'b1;
      req_valid[0] = 1'b1;
      wait_hs(h);
      req_valid[1] = 1'b0;
      k = 0;
      while (!rsp_valid && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      repeat (5) begin
         @(negedge clk);
         chk("bp_sum", 64'(rsp_sum), 64'h2345_6789);
         chk("bp_id", 64'(rsp_id), 64'd1);
         chk("bp_ready", 64'(req_ready), 64'd0);
      end
      @(posedge clk); #1;
      r = rsp_count + 2;
      rsp_ready = 1'b1;
      wait_hs(h + 1);
      req_valid[0] = 1'b0;
      wait_rsp(r);
      chk_last("bp_next", 0, 32'd16, 1'b0);

      // Reset during CALC discards the op and clears the pointer
      do_one(2, 32'h10, 32'h20);
      chk_last("pre_rst", 2, 32'h30, 1'b0);
      set_req(3, 32'h1, 32'h2);
      h = hs_count + 1;
      req_valid[3] = 1'b1;
      wait_hs(h);
      req_valid[3] = 1'b0;
      req_valid[2] = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("lit_midrst_rvalid", 64'(rsp_valid), 64'd0);
      chk("lit_midrst_ready", 64'(req_ready), 64'd0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      req_valid = 4'b1010;
      set_req(1, 32'hA, 32'hB);
      r = rsp_count + 1;
      wait_hs(hs_count + 1);
      req_valid = '0;
      wait_rsp(r);
      chk_last("post_rst", 1, 32'h15, 1'b0);

      // Lock: requester 1 with lock held once, then released
      do_one(0, 32'h1, 32'h1);
      chk_last("pre_lock", 0, 32'h2, 1'b0);
      set_req(1, 32'h100, 32'h1);
      set_req(2, 32'h200, 32'h2);
      base = lg_id.size();
      h = hs_count;
      r = rsp_count + 3;
      req_lock[1] = 1'b1;
      req_valid = 4'b0110;
      wait_hs(h + 1);
      req_lock[1] = 1'b0;
      wait_hs(h + 3);
      req_valid = '0;
      wait_rsp(r);
`ifdef ADDER_SCHED_LOCK_EN
      exp_lock = '{1, 1, 2};
`else
      exp_lock = '{1, 2, 1};
`endif
      for (int i = 0; i < 3; i++)
         chk("lock_order", 64'(lg_id[base + i]), 64'(exp_lock[i]));

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
